// File: rtl/vscale_md_issue.sv
// Issue/writeback sequencer for RV32M ops in front of vscale_mul_div.
// Divide-by-zero and signed-overflow results are resolved locally when BYPASS_SPECIAL=1.
module vscale_md_issue #(
    parameter int unsigned BYPASS_SPECIAL   = 1,
    parameter int unsigned XPR_LEN          = 32,
    parameter int unsigned MD_OP_WIDTH      = 2,
    parameter int unsigned MD_OUT_SEL_WIDTH = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        issue_valid,
    output logic                        issue_ready,
    input  logic [2:0]                  issue_funct3,
    input  logic [XPR_LEN-1:0]          issue_rs1,
    input  logic [XPR_LEN-1:0]          issue_rs2,
    input  logic [4:0]                  issue_rd,
    input  logic                        kill,
    output logic                        md_req_valid,
    input  logic                        md_req_ready,
    output logic [MD_OP_WIDTH-1:0]      md_req_op,
    output logic [MD_OUT_SEL_WIDTH-1:0] md_req_out_sel,
    output logic                        md_req_in_1_signed,
    output logic                        md_req_in_2_signed,
    output logic [XPR_LEN-1:0]          md_req_in_1,
    output logic [XPR_LEN-1:0]          md_req_in_2,
    input  logic                        md_resp_valid,
    input  logic [XPR_LEN-1:0]          md_resp_result,
    output logic                        wb_valid,
    input  logic                        wb_ready,
    output logic [4:0]                  wb_rd,
    output logic [XPR_LEN-1:0]          wb_data
);

    localparam logic [MD_OP_WIDTH-1:0]      MD_OP_MUL  = 0;
    localparam logic [MD_OP_WIDTH-1:0]      MD_OP_DIV  = 1;
    localparam logic [MD_OP_WIDTH-1:0]      MD_OP_REM  = 2;
    localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_LO  = 0;
    localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_HI  = 1;
    localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_REM = 2;
    localparam logic [XPR_LEN-1:0]          XPR_MIN    = {1'b1, {(XPR_LEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN,
        S_WB
    } state_t;

    state_t                      state_q, state_d;
    logic                        issue_ready_q, issue_ready_d;
    logic                        md_req_valid_q, md_req_valid_d;
    logic                        wb_valid_q, wb_valid_d;
    logic [MD_OP_WIDTH-1:0]      md_req_op_q, md_req_op_d;
    logic [MD_OUT_SEL_WIDTH-1:0] md_req_out_sel_q, md_req_out_sel_d;
    logic                        in_1_signed_q, in_1_signed_d;
    logic                        in_2_signed_q, in_2_signed_d;
    logic [XPR_LEN-1:0]          in_1_q, in_1_d;
    logic [XPR_LEN-1:0]          in_2_q, in_2_d;
    logic [4:0]                  wb_rd_q, wb_rd_d;
    logic [XPR_LEN-1:0]          wb_data_q, wb_data_d;

    logic [MD_OP_WIDTH-1:0]      dec_op;
    logic [MD_OUT_SEL_WIDTH-1:0] dec_out_sel;
    logic                        dec_s1, dec_s2;
    logic                        rs2_zero, overflow, special;
    logic [XPR_LEN-1:0]          special_result;

    always_comb begin
        dec_op      = MD_OP_MUL;
        dec_out_sel = MD_OUT_LO;
        dec_s1      = 1'b0;
        dec_s2      = 1'b0;
        case (issue_funct3)
            3'b000: begin dec_op = MD_OP_MUL; dec_out_sel = MD_OUT_LO;  end
            3'b001: begin dec_op = MD_OP_MUL; dec_out_sel = MD_OUT_HI;  dec_s1 = 1'b1; dec_s2 = 1'b1; end
            3'b010: begin dec_op = MD_OP_MUL; dec_out_sel = MD_OUT_HI;  dec_s1 = 1'b1; end
            3'b011: begin dec_op = MD_OP_MUL; dec_out_sel = MD_OUT_HI;  end
            3'b100: begin dec_op = MD_OP_DIV; dec_out_sel = MD_OUT_LO;  dec_s1 = 1'b1; dec_s2 = 1'b1; end
            3'b101: begin dec_op = MD_OP_DIV; dec_out_sel = MD_OUT_LO;  end
            3'b110: begin dec_op = MD_OP_REM; dec_out_sel = MD_OUT_REM; dec_s1 = 1'b1; dec_s2 = 1'b1; end
            default: begin dec_op = MD_OP_REM; dec_out_sel = MD_OUT_REM; end
        endcase

        // Divide-by-zero takes priority; funct3[1] distinguishes REM from DIV.
        rs2_zero = (issue_rs2 == '0);
        overflow = issue_funct3[2] && !issue_funct3[0]
                   && (issue_rs1 == XPR_MIN) && (issue_rs2 == '1);
        special  = (BYPASS_SPECIAL != 0) && issue_funct3[2] && (rs2_zero || overflow);
        if (rs2_zero) begin
            special_result = issue_funct3[1] ? issue_rs1 : '1;
        end else begin
            special_result = issue_funct3[1] ? '0 : XPR_MIN;
        end
    end

    always_comb begin
        state_d          = state_q;
        md_req_op_d      = md_req_op_q;
        md_req_out_sel_d = md_req_out_sel_q;
        in_1_signed_d    = in_1_signed_q;
        in_2_signed_d    = in_2_signed_q;
        in_1_d           = in_1_q;
        in_2_d           = in_2_q;
        wb_rd_d          = wb_rd_q;
        wb_data_d        = wb_data_q;

        case (state_q)
            S_IDLE: begin
                if (issue_valid && !kill) begin
                    md_req_op_d      = dec_op;
                    md_req_out_sel_d = dec_out_sel;
                    in_1_signed_d    = dec_s1;
                    in_2_signed_d    = dec_s2;
                    in_1_d           = issue_rs1;
                    in_2_d           = issue_rs2;
                    wb_rd_d          = issue_rd;
                    if (special) begin
                        wb_data_d = special_result;
                        state_d   = S_WB;
                    end else begin
                        state_d   = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (kill) begin
                    state_d = md_req_ready ? S_DRAIN : S_IDLE;
                end else if (md_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (md_resp_valid) begin
                    if (kill) begin
                        state_d = S_IDLE;
                    end else begin
                        wb_data_d = md_resp_result;
                        state_d   = S_WB;
                    end
                end else if (kill) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (md_resp_valid) begin
                    state_d = S_IDLE;
                end
            end
            S_WB: begin
                if (wb_ready || kill) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Handshake outputs are registered copies of the next-state decode.
        issue_ready_d  = (state_d == S_IDLE);
        md_req_valid_d = (state_d == S_REQ);
        wb_valid_d     = (state_d == S_WB);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            issue_ready_q    <= 1'b1;
            md_req_valid_q   <= 1'b0;
            wb_valid_q       <= 1'b0;
            md_req_op_q      <= '0;
            md_req_out_sel_q <= '0;
            in_1_signed_q    <= 1'b0;
            in_2_signed_q    <= 1'b0;
            in_1_q           <= '0;
            in_2_q           <= '0;
            wb_rd_q          <= '0;
            wb_data_q        <= '0;
        end else begin
            state_q          <= state_d;
            issue_ready_q    <= issue_ready_d;
            md_req_valid_q   <= md_req_valid_d;
            wb_valid_q       <= wb_valid_d;
            md_req_op_q      <= md_req_op_d;
            md_req_out_sel_q <= md_req_out_sel_d;
            in_1_signed_q    <= in_1_signed_d;
            in_2_signed_q    <= in_2_signed_d;
            in_1_q           <= in_1_d;
            in_2_q           <= in_2_d;
            wb_rd_q          <= wb_rd_d;
            wb_data_q        <= wb_data_d;
        end
    end

    assign issue_ready        = issue_ready_q;
    assign md_req_valid       = md_req_valid_q;
    assign md_req_op          = md_req_op_q;
    assign md_req_out_sel     = md_req_out_sel_q;
    assign md_req_in_1_signed = in_1_signed_q;
    assign md_req_in_2_signed = in_2_signed_q;
    assign md_req_in_1        = in_1_q;
    assign md_req_in_2        = in_2_q;
    assign wb_valid           = wb_valid_q;
    assign wb_rd              = wb_rd_q;
    assign wb_data            = wb_data_q;

endmodule

// File: doc/vscale_md_issue.md
# vscale_md_issue

Issue/writeback sequencer between the execute stage and `vscale_mul_div`. It accepts one RV32M instruction at a time and decodes funct3 into the multiplier/divider request fields. It resolves divide-by-zero and signed-overflow cases locally, without using the divider, and holds the result for writeback under a valid/ready handshake. A pipeline kill discards an in-flight operation without corrupting the divider.

## Interface
Parameters:
- `BYPASS_SPECIAL`, default 1: when 1, div-by-zero and signed-overflow results are produced locally; when 0, every op goes to `vscale_mul_div`.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `issue_valid`  in  1  execute stage presents an M-extension op.
- `issue_ready`  out  1  block can accept an op.
- `issue_funct3`  in  3  RV32M funct3.
- `issue_rs1`, `issue_rs2`  in  `XPR_LEN`  operand values.
- `issue_rd`  in  5  destination register.
- `kill`  in  1  pipeline flush; aborts the current op.
- `md_req_valid`  out  1  request to `vscale_mul_div`.
- `md_req_ready`  in  1  divider ready.
- `md_req_op`  out  `MD_OP_WIDTH`  op code.
- `md_req_out_sel`  out  `MD_OUT_SEL_WIDTH`  output select.
- `md_req_in_1_signed`, `md_req_in_2_signed`  out  1 each  operand signedness.
- `md_req_in_1`, `md_req_in_2`  out  `XPR_LEN`  operands.
- `md_resp_valid`  in  1  divider result strobe (one cycle).
- `md_resp_result`  in  `XPR_LEN`  divider result.
- `wb_valid`  out  1  result available for writeback.
- `wb_ready`  in  1  writeback port accepts.
- `wb_rd`  out  5  destination register.
- `wb_data`  out  `XPR_LEN`  result.

## Operation
Decode from funct3, registered at accept (op, out_sel, in_1_signed, in_2_signed):
- 000 MUL: `MD_OP_MUL`, `MD_OUT_LO`, 0, 0.
- 001 MULH: `MD_OP_MUL`, `MD_OUT_HI`, 1, 1.
- 010 MULHSU: `MD_OP_MUL`, `MD_OUT_HI`, 1, 0.
- 011 MULHU: `MD_OP_MUL`, `MD_OUT_HI`, 0, 0.
- 100 DIV: `MD_OP_DIV`, `MD_OUT_LO`, 1, 1.
- 101 DIVU: `MD_OP_DIV`, `MD_OUT_LO`, 0, 0.
- 110 REM: `MD_OP_REM`, `MD_OUT_REM`, 1, 1.
- 111 REMU: `MD_OP_REM`, `MD_OUT_REM`, 0, 0.

Special cases (`BYPASS_SPECIAL`=1; evaluated on issue operands at accept):
- funct3[2]=1 and rs2=0: DIV/DIVU result all ones; REM/REMU result rs1.
- funct3 100/110, rs1=0x80000000, rs2=0xFFFFFFFF: DIV result 0x80000000; REM result 0.
- A special case goes straight to S_WB; no `md_req_valid` is raised.

FSM states:
- S_IDLE:
  - `issue_ready`=1.
  - On `issue_valid` & !`kill`: capture operands, decode and rd; go to S_WB (special case) or S_REQ.
- S_REQ:
  - `md_req_valid`=1; request fields held stable.
  - `md_req_valid` & `md_req_ready` -> S_WAIT.
  - `kill` with no transfer this cycle -> S_IDLE.
  - `kill` in the same cycle as a transfer -> S_DRAIN.
- S_WAIT:
  - On `md_resp_valid`: capture `md_resp_result` into `wb_data`; -> S_WB.
  - `kill` (without `md_resp_valid`) -> S_DRAIN.
  - `kill` together with `md_resp_valid`: the result is discarded; -> S_IDLE.
- S_DRAIN: wait for `md_resp_valid`, discard the result, -> S_IDLE. `issue_ready`=0 in this state.
- S_WB:
  - `wb_valid`=1; `wb_rd` and `wb_data` held stable.
  - `wb_ready` -> S_IDLE.
  - `kill` -> S_IDLE with no transfer.

General rules:
- `issue_ready` is 1 only in S_IDLE.
- Only one op is in flight at a time.

## Timing
- Reset (async assert, sync deassert is the integrator's job):
  - state S_IDLE.
  - `issue_ready`=1.
  - `md_req_valid`=0, `wb_valid`=0.
  - `wb_data`=0, `wb_rd`=0, all `md_req_*` data fields=0.
- Reset mid-operation returns to S_IDLE immediately. The divider is reset by the same network; no drain is needed.
- Accept at edge E0:
  - Normal op: `md_req_valid` high from E0.
  - Special case: `wb_valid` high from E0 (1-cycle latency).
- The divider transfer edge is the first edge with `md_req_valid` & `md_req_ready`.
- `md_resp_valid` at edge En -> `wb_valid` from En. End-to-end latency is divider latency + 2 cycles.
- `wb_valid`, once raised, stays high until `wb_ready` or `kill`. Data does not change while held.
- The block does not accept the next op until the writeback edge. It never accepts in the same cycle that `wb_valid` drops.

## Test plan
- MULHU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> `md_req_op`=MUL, `md_req_out_sel`=HI, unsigned; `wb_data`=0xFFFFFFFE.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> `wb_data`=0xFFFFFFFD; REM of the same operands -> 0xFFFFFFFF.
- DIVU rs1=0x1234, rs2=0 -> no `md_req_valid` ever; `wb_valid` one cycle after accept with `wb_data`=0xFFFFFFFF. REMU of the same operands -> 0x1234.
- REM rs1=0x80000000, rs2=0xFFFFFFFF -> bypass, `wb_data`=0. DIV of the same operands -> 0x80000000.
- Kill in S_WAIT:
  - Required: no `wb_valid`; `issue_ready` stays 0 until the divider's `md_resp_valid`, then 1.
  - Follow-up: a following MUL 3*5 -> `wb_data`=15.
- Backpressure and reset:
  - `wb_ready` held 0 for 5 cycles -> `wb_valid`/`wb_data`/`wb_rd` stable throughout; a single transfer occurs when `wb_ready` rises.
  - `reset_n` pulsed low in S_WAIT -> all outputs at reset values asynchronously.
